field_line_clear: RTL

- Reader/consumer of the stored playfield held by the field background register.
- On a start pulse it snapshots the 400-bit field and scans it one row per cycle, bottom to top.
- Full rows are removed and the surviving rows are compacted downward.
- It produces the compacted field, a mask of removed rows and a cleared-line count; the top-level writes the compacted field back into the background register.

---
 rtl/tetris_field_pkg.sv | 31 +++
 rtl/field_line_clear_row_full_check.sv | 17 +
 rtl/field_line_clear.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tetris_field_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_field_pkg
// Description : Playfield geometry, row index type, line-clear FSM states and
//               the row-slice helper shared by the field blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_field_pkg;

    localparam int ROWS      = 20;
    localparam int COLS      = 20;
    localparam int FIELD_W   = ROWS * COLS;
    localparam int CNT_W     = 5;
    localparam int ROW_IDX_W = $clog2(ROWS);

    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row r of a flat field vector occupies bits r*COLS +: COLS (row 0 = top).
    function automatic logic [COLS-1:0] row_slice(input logic [FIELD_W-1:0] field,
                                                  input row_idx_t           r);
        return field[r*COLS +: COLS];
    endfunction

endpackage : tetris_field_pkg
`default_nettype wire

// File: rtl/field_line_clear_row_full_check.sv
`default_nettype none
// ============================================================================
// Module      : row_full_check
// Description : Flags a playfield row whose cells are all occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module row_full_check #(
    parameter int COLS = 20
) (
    input  logic [COLS-1:0] row,
    output logic            full
);

    assign full = &row;

endmodule : row_full_check
`default_nettype wire

// File: rtl/field_line_clear.sv
`default_nettype none
// ============================================================================
// Module      : field_line_clear
// Description : Snapshots the stored field on start, scans it bottom-to-top one
//               row per cycle, drops full rows and compacts the survivors
//               downward. Reports compacted field, removed-row mask and count.
// Revision    : 1.0 - initial release
// ============================================================================
module field_line_clear
    import tetris_field_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FIELD_W-1:0] field_in,
    output logic               busy,
    output logic               done,
    output logic [FIELD_W-1:0] field_out,
    output logic [ROWS-1:0]    row_mask,
    output logic [CNT_W-1:0]   lines_cleared
);

    localparam row_idx_t c_last_row = row_idx_t'(ROWS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [FIELD_W-1:0]       r_snap;
    logic [ROWS-1:0][COLS-1:0] r_res;
    logic [ROWS-1:0][COLS-1:0] w_res_nxt;
    row_idx_t                 r_rd;
    row_idx_t                 r_wr;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [ROWS-1:0]          r_mask;
    logic [ROWS-1:0]          w_mask_nxt;

    logic [ROWS-1:0][COLS-1:0] r_field_out;
    logic [ROWS-1:0]          r_row_mask;
    logic [CNT_W-1:0]         r_lines_cleared;

    logic [COLS-1:0]          w_row;
    logic                     w_row_full;
    logic                     w_last_row;

    assign w_row      = row_slice(r_snap, r_rd);
    assign w_last_row = (r_rd == '0);

    row_full_check #(
        .COLS (COLS)
    ) u_row_full_check (
        .row  (w_row),
        .full (w_row_full)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: start only matters in IDLE; SCAN ends after row 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN;
            SCAN:    if (w_last_row) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Effect of the current row on the buffers; used both for the running
    // state and for the final results, so the last row lands in the outputs.
    always_comb begin
        w_res_nxt  = r_res;
        w_mask_nxt = r_mask;
        w_cnt_nxt  = r_cnt;
        if (w_row_full) begin
            w_mask_nxt[r_rd] = 1'b1;
            w_cnt_nxt        = r_cnt + 1'b1;
        end else begin
            w_res_nxt[r_wr]  = w_row;
        end
    end

    // Capture, scan pointers/buffers, and result registers loaded on SCAN->DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap          <= '0;
            r_res           <= '0;
            r_rd            <= '0;
            r_wr            <= '0;
            r_cnt           <= '0;
            r_mask          <= '0;
            r_field_out     <= '0;
            r_row_mask      <= '0;
            r_lines_cleared <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_snap <= field_in;
                        r_res  <= '0;
                        r_rd   <= c_last_row;
                        r_wr   <= c_last_row;
                        r_cnt  <= '0;
                        r_mask <= '0;
                    end
                end
                SCAN: begin
                    r_res  <= w_res_nxt;
                    r_mask <= w_mask_nxt;
                    r_cnt  <= w_cnt_nxt;
                    r_rd   <= r_rd - 1'b1;
                    // The decrement after a copy into row 0 wraps harmlessly.
                    if (!w_row_full) begin
                        r_wr <= r_wr - 1'b1;
                    end
                    if (w_last_row) begin
                        r_field_out     <= w_res_nxt;
                        r_row_mask      <= w_mask_nxt;
                        r_lines_cleared <= w_cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state == SCAN);
    assign done          = (r_state == DONE);
    assign field_out     = r_field_out;
    assign row_mask      = r_row_mask;
    assign lines_cleared = r_lines_cleared;

endmodule : field_line_clear
`default_nettype wire
